bus_src_mux: RTL and testbench
==============================

Name: bus_src_mux

Overview:
- Registered, parametrised source selector for the CPU internal data bus; replaces the fixed 5-input combinational one-hot bus mux.
- Concatenated NSRC x WIDTH source vector; one-hot select qualified by a valid strobe.
- Registers the chosen source and flags illegal select codes with a sticky fault state.
- Counts completed transfers for debug.

Parameters:
- WIDTH, 8, data width of each source and of the bus output.
- NSRC, 5, number of sources; select width equals NSRC; bit NSRC-1 selects slot 0 (MSB-first, matching the existing A/B/C/D/Buffer0 order).
- CNT_W, 8, width of the transfer counter.

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- src_i  in  NSRC*WIDTH  source vector; slot k occupies bits [(NSRC-1-k)*WIDTH +: WIDTH]; slot 0 is most significant.
- sel_i  in  NSRC  one-hot select; bit NSRC-1-k selects slot k.
- sel_valid_i  in  1  qualifies sel_i this cycle.
- err_clr_i  in  1  clears fault state.
- result_o  out  WIDTH  registered bus value.
- bus_valid_o  out  1  one-cycle pulse: result_o updated from a legal select.
- err_o  out  1  high while in FAULT.
- err_sel_o  out  NSRC  captured illegal select code.
- last_sel_o  out  NSRC  select code of last legal transfer.
- xfer_cnt_o  out  CNT_W  count of legal transfers, wraps.

Behaviour:
- Reset (rst_i high at clock edge, overrides everything):
  - result_o=0, bus_valid_o=0, err_o=0, err_sel_o=0, last_sel_o=0, xfer_cnt_o=0.
  - State becomes IDLE.
  - Reset mid-transfer discards the pending capture.
- States:
  - IDLE: no transfer last cycle.
  - DRIVE: a legal transfer was captured last cycle.
  - FAULT: an illegal select was seen.
- A legal request means sel_valid_i=1 and sel_i has exactly one bit set.
- A legal request in IDLE or DRIVE:
  - Next edge: result_o takes the selected slot, last_sel_o takes sel_i, bus_valid_o=1, xfer_cnt_o increments.
  - State goes to DRIVE.
  - Latency is 1 cycle from request to result_o/bus_valid_o.
- Back-to-back legal requests give one result per cycle; bus_valid_o stays high continuously.
- No request in IDLE or DRIVE (sel_valid_i=0):
  - bus_valid_o=0, result_o holds its last value, state goes to IDLE.
  - sel_i is ignored when sel_valid_i=0, whatever its value.
- An illegal request in IDLE or DRIVE (sel_valid_i=1 with sel_i zero or multi-hot):
  - Next edge: state FAULT, err_o=1, err_sel_o=sel_i, bus_valid_o=0.
  - result_o, last_sel_o and xfer_cnt_o hold.
- In FAULT:
  - All requests are ignored: no capture, no count, err_sel_o frozen at the first fault.
  - err_o stays high until err_clr_i.
- err_clr_i=1 in FAULT:
  - Next edge: state IDLE, err_o=0, err_sel_o=0.
  - Any request in the same cycle is ignored.
- err_clr_i in IDLE or DRIVE has no effect.
- Counter: xfer_cnt_o wraps from 2^CNT_W-1 to 0 with no flag.
- The design is fully synchronous; no latches; no inferred sensitivity-list hazards.

Optional Feature:
- Macro BUS_SRC_MUX_ZDRIVE_EN: tristate bus drive.
- Defined:
  - result_o is driven from the output register only while bus_valid_o=1; otherwise it is high-impedance.
  - This covers reset, IDLE and FAULT.
  - Intended for a shared wired bus.
- Undefined:
  - result_o is always driven.
  - It holds the last registered value as above and is never Z.

Test Plan:
- Reset then sel_valid_i=0 for 3 cycles -> result_o=0x00, bus_valid_o=0, xfer_cnt_o=0, err_o=0.
- NSRC=5, src_i = slots 0..4 of 0x11,0x22,0x33,0x44,0x55.
  - Back-to-back selects 5'b10000, 5'b00100, 5'b00001 on cycles 1-3.
  - Expect result_o 0x11, 0x33, 0x55 on cycles 2-4, bus_valid_o high cycles 2-4 then low, xfer_cnt_o=3, last_sel_o=5'b00001.
- Valid select 5'b01100 -> next cycle err_o=1, err_sel_o=5'b01100, result_o unchanged.
  - Then legal 5'b01000 -> ignored, xfer_cnt_o unchanged.
  - Then err_clr_i together with 5'b01000 -> err_o=0, no capture.
  - Then 5'b01000 -> result_o=0x22.
- Valid select 5'b00000 -> err_o=1, err_sel_o=0.
- CNT_W=2, 5 legal transfers -> xfer_cnt_o sequence 1,2,3,0,1.
- rst_i asserted in the same cycle as a legal request -> next cycle all outputs 0, state IDLE.
- With BUS_SRC_MUX_ZDRIVE_EN, one transfer of 0x44 -> result_o=0x44 for one cycle, 'z before and after.

Source files
------------

// File: rtl/bus_src_mux.sv
// Registered one-hot source selector for the CPU internal data bus, with sticky
// illegal-select fault and transfer counter. Optional: BUS_SRC_MUX_ZDRIVE_EN (tristate result_o).
module bus_src_mux #(
  parameter int WIDTH = 8,
  parameter int NSRC  = 5,
  parameter int CNT_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NSRC*WIDTH-1:0] src_i,
  input  logic [NSRC-1:0]       sel_i,
  input  logic                  sel_valid_i,
  input  logic                  err_clr_i,
  output logic [WIDTH-1:0]      result_o,
  output logic                  bus_valid_o,
  output logic                  err_o,
  output logic [NSRC-1:0]       err_sel_o,
  output logic [NSRC-1:0]       last_sel_o,
  output logic [CNT_W-1:0]      xfer_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_FAULT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             valid_q, valid_d;
  logic [NSRC-1:0]  err_sel_q, err_sel_d;
  logic [NSRC-1:0]  last_sel_q, last_sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] sel_data;
  logic             sel_onehot;
  logic             legal_req;

  // Select bit j and slot bits [j*WIDTH +: WIDTH] line up, so slot 0 (MSB) is bit NSRC-1.
  always_comb begin
    sel_data = '0;
    for (int j = 0; j < NSRC; j++) begin
      if (sel_i[j]) sel_data = sel_data | src_i[j*WIDTH +: WIDTH];
    end
  end

  assign sel_onehot = (sel_i != '0) && ((sel_i & (sel_i - NSRC'(1))) == '0);
  assign legal_req  = sel_valid_i && sel_onehot;

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    valid_d    = 1'b0;
    err_sel_d  = err_sel_q;
    last_sel_d = last_sel_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE, S_DRIVE: begin
        if (legal_req) begin
          state_d    = S_DRIVE;
          result_d   = sel_data;
          valid_d    = 1'b1;
          last_sel_d = sel_i;
          cnt_d      = cnt_q + CNT_W'(1);
        end else if (sel_valid_i) begin
          state_d   = S_FAULT;
          err_sel_d = sel_i;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FAULT: begin
        // Requests are dropped while faulted, including the one alongside the clear.
        if (err_clr_i) begin
          state_d   = S_IDLE;
          err_sel_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      result_q   <= '0;
      valid_q    <= 1'b0;
      err_sel_q  <= '0;
      last_sel_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
      err_sel_q  <= err_sel_d;
      last_sel_q <= last_sel_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef BUS_SRC_MUX_ZDRIVE_EN
  // Shared wired bus: release the lines whenever no fresh transfer is presented.
  assign result_o = valid_q ? result_q : {WIDTH{1'bz}};
`else
  assign result_o = result_q;
`endif

  assign bus_valid_o = valid_q;
  assign err_o       = (state_q == S_FAULT);
  assign err_sel_o   = err_sel_q;
  assign last_sel_o  = last_sel_q;
  assign xfer_cnt_o  = cnt_q;

endmodule

// File: tb/tb_bus_src_mux.sv
// Directed bench for bus_src_mux: vector table on a default instance plus a
// CNT_W=2 instance for counter wrap and an optional tristate sequence.
module tb_bus_src_mux;

  localparam int W = 8;
  localparam int N = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] src;
  logic [N-1:0]   sel, sel2;
  logic           vld, vld2;
  logic           clr;

  wire  [W-1:0]   res;
  logic           bv, err;
  logic [N-1:0]   es, ls;
  logic [7:0]     cnt;

  logic [W-1:0]   res2;
  logic           bv2, err2;
  logic [N-1:0]   es2, ls2;
  logic [1:0]     cnt2;

  int n_chk  = 0;
  int n_fail = 0;

  logic [W+1:0] exp_q[$];

  always #5 clk = ~clk;

  bus_src_mux #(.WIDTH(W), .NSRC(N), .CNT_W(8)) u_dut (
    .clk_i(clk), .rst_i(rst), .src_i(src), .sel_i(sel), .sel_valid_i(vld),
    .err_clr_i(clr), .result_o(res), .bus_valid_o(bv), .err_o(err),
    .err_sel_o(es), .last_sel_o(ls), .xfer_cnt_o(cnt)
  );

  bus_src_mux #(.WIDTH(W), .NSRC(N), .CNT_W(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .src_i(src), .sel_i(sel2), .sel_valid_i(vld2),
    .err_clr_i(1'b0), .result_o(res2), .bus_valid_o(bv2), .err_o(err2),
    .err_sel_o(es2), .last_sel_o(ls2), .xfer_cnt_o(cnt2)
  );

  typedef struct {
    logic         rst;
    logic         v;
    logic [N-1:0] sel;
    logic         clr;
    logic [W-1:0] res;
    logic         bv;
    logic         err;
    logic [N-1:0] es;
    logic [N-1:0] ls;
    logic [7:0]   cnt;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [N-1:0] s, input logic c);
    rst = r; vld = v; sel = s; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_main(input string tag, input logic [W-1:0] e_res, input logic e_bv,
                            input logic e_err, input logic [N-1:0] e_es,
                            input logic [N-1:0] e_ls, input logic [7:0] e_cnt);
    logic [W-1:0] want_res;
    want_res = e_res;
`ifdef BUS_SRC_MUX_ZDRIVE_EN
    if (!e_bv) want_res = {W{1'bz}};
`endif
    chk({tag, " result"},   32'(res), 32'(want_res));
    chk({tag, " bus_valid"}, 32'(bv), 32'(e_bv));
    chk({tag, " err"},      32'(err), 32'(e_err));
    chk({tag, " err_sel"},  32'(es),  32'(e_es));
    chk({tag, " last_sel"}, 32'(ls),  32'(e_ls));
    chk({tag, " xfer_cnt"}, 32'(cnt), 32'(e_cnt));
  endtask

  initial begin
    logic [W+1:0] e;
    logic [N-1:0] s2_tab[5];

    rst = 1'b1; vld = 1'b0; sel = '0; clr = 1'b0; vld2 = 1'b0; sel2 = '0;
    // Slots 0..4 = 11,22,33,44,55 with slot 0 most significant.
    src = 40'h11_22_33_44_55;

    //         rst  v    sel       clr   res    bv   err  es        ls        cnt
    vecs[0]  = '{1'b0, 1'b0, 5'b00000, 1'b0, 8'h00, 1'b0, 1'b0, 5'b00000, 5'b00000, 8'd0};
    vecs[1]  = '{1'b0, 1'b0, 5'b00000, 1'b0, 8'h00, 1'b0, 1'b0, 5'b00000, 5'b00000, 8'd0};
    vecs[2]  = '{1'b0, 1'b0, 5'b11111, 1'b0, 8'h00, 1'b0, 1'b0, 5'b00000, 5'b00000, 8'd0};
    vecs[3]  = '{1'b0, 1'b1, 5'b10000, 1'b0, 8'h11, 1'b1, 1'b0, 5'b00000, 5'b10000, 8'd1};
    vecs[4]  = '{1'b0, 1'b1, 5'b00100, 1'b0, 8'h33, 1'b1, 1'b0, 5'b00000, 5'b00100, 8'd2};
    vecs[5]  = '{1'b0, 1'b1, 5'b00001, 1'b0, 8'h55, 1'b1, 1'b0, 5'b00000, 5'b00001, 8'd3};
    vecs[6]  = '{1'b0, 1'b0, 5'b00000, 1'b0, 8'h55, 1'b0, 1'b0, 5'b00000, 5'b00001, 8'd3};
    vecs[7]  = '{1'b0, 1'b1, 5'b01100, 1'b0, 8'h55, 1'b0, 1'b1, 5'b01100, 5'b00001, 8'd3};
    vecs[8]  = '{1'b0, 1'b1, 5'b01000, 1'b0, 8'h55, 1'b0, 1'b1, 5'b01100, 5'b00001, 8'd3};
    vecs[9]  = '{1'b0, 1'b1, 5'b01000, 1'b1, 8'h55, 1'b0, 1'b0, 5'b00000, 5'b00001, 8'd3};
    vecs[10] = '{1'b0, 1'b1, 5'b01000, 1'b0, 8'h22, 1'b1, 1'b0, 5'b00000, 5'b01000, 8'd4};
    vecs[11] = '{1'b0, 1'b0, 5'b00000, 1'b1, 8'h22, 1'b0, 1'b0, 5'b00000, 5'b01000, 8'd4};
    vecs[12] = '{1'b0, 1'b1, 5'b00000, 1'b0, 8'h22, 1'b0, 1'b1, 5'b00000, 5'b01000, 8'd4};
    vecs[13] = '{1'b0, 1'b1, 5'b00010, 1'b0, 8'h22, 1'b0, 1'b1, 5'b00000, 5'b01000, 8'd4};
    vecs[14] = '{1'b0, 1'b0, 5'b00000, 1'b1, 8'h22, 1'b0, 1'b0, 5'b00000, 5'b01000, 8'd4};
    vecs[15] = '{1'b0, 1'b1, 5'b00010, 1'b0, 8'h44, 1'b1, 1'b0, 5'b00000, 5'b00010, 8'd5};
    vecs[16] = '{1'b1, 1'b1, 5'b10000, 1'b0, 8'h00, 1'b0, 1'b0, 5'b00000, 5'b00000, 8'd0};
    vecs[17] = '{1'b0, 1'b0, 5'b00000, 1'b0, 8'h00, 1'b0, 1'b0, 5'b00000, 5'b00000, 8'd0};
    vecs[18] = '{1'b0, 1'b1, 5'b00001, 1'b0, 8'h55, 1'b1, 1'b0, 5'b00000, 5'b00001, 8'd1};
    vecs[19] = '{1'b0, 1'b1, 5'b11000, 1'b0, 8'h55, 1'b0, 1'b1, 5'b11000, 5'b00001, 8'd1};
    vecs[20] = '{1'b1, 1'b0, 5'b00000, 1'b0, 8'h00, 1'b0, 1'b0, 5'b00000, 5'b00000, 8'd0};

    // Clock/reset block.
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    check_main("reset", 8'h00, 1'b0, 1'b0, 5'b00000, 5'b00000, 8'd0);

    for (int i = 0; i < 21; i++) begin
      step(vecs[i].rst, vecs[i].v, vecs[i].sel, vecs[i].clr);
      check_main($sformatf("vec%0d", i), vecs[i].res, vecs[i].bv, vecs[i].err,
                 vecs[i].es, vecs[i].ls, vecs[i].cnt);
    end
    step(1'b0, 1'b0, '0, 1'b0);

    // Two-bit counter wrap on the second instance, back-to-back transfers.
    s2_tab[0] = 5'b10000; s2_tab[1] = 5'b01000; s2_tab[2] = 5'b00100;
    s2_tab[3] = 5'b00010; s2_tab[4] = 5'b00001;
    exp_q.push_back({2'd1, 8'h11});
    exp_q.push_back({2'd2, 8'h22});
    exp_q.push_back({2'd3, 8'h33});
    exp_q.push_back({2'd0, 8'h44});
    exp_q.push_back({2'd1, 8'h55});
    for (int i = 0; i < 5; i++) begin
      vld2 = 1'b1; sel2 = s2_tab[i];
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("wrap%0d cnt", i),    32'(cnt2), 32'(e[W+1:W]));
      chk($sformatf("wrap%0d result", i), 32'(res2), 32'(e[W-1:0]));
      chk($sformatf("wrap%0d valid", i),  32'(bv2),  32'd1);
    end
    vld2 = 1'b0; sel2 = '0;
    @(posedge clk);
    #1;
    chk("wrap idle valid", 32'(bv2), 32'd0);
    chk("wrap idle cnt",   32'(cnt2), 32'd1);
    chk("wrap idle err",   32'(err2), 32'd0);

`ifdef BUS_SRC_MUX_ZDRIVE_EN
    step(1'b0, 1'b0, '0, 1'b0);
    chk("z before", 32'(res), 32'(8'hzz));
    step(1'b0, 1'b1, 5'b00010, 1'b0);
    chk("z drive",  32'(res), 32'(8'h44));
    step(1'b0, 1'b0, '0, 1'b0);
    chk("z after",  32'(res), 32'(8'hzz));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
